// File: rtl/rah_version_request.sv
// Version handshake initiator: one request per attempt, drains RX until a response, then flags match/mismatch/timeout.
// done 3 cycles after the response pop; w_en stalls while tx_full; pops only when !q_empty. RAH_VERSION_RETRY_EN re-requests on timeout.
module rah_version_request #(
  parameter int          RAH_PACKET_WIDTH = 32,
  parameter logic [15:0] EXPECTED_VERSION = 16'h0001,
  parameter logic [7:0]  REQ_OPCODE       = 8'hA5,
  parameter logic [7:0]  RSP_OPCODE       = 8'h5A,
  parameter int          TIMEOUT_CYCLES   = 1024,
  parameter int          MAX_RETRIES      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [RAH_PACKET_WIDTH-1:0] in_data,
  input  logic                        q_empty,
  output logic                        request_data,
  input  logic                        tx_full,
  output logic                        w_en,
  output logic [RAH_PACKET_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic                        done,
  output logic                        match,
  output logic                        timeout,
  output logic [15:0]                 rx_version
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [RAH_PACKET_WIDTH-1:0] REQ_PKT = {REQ_OPCODE, {(RAH_PACKET_WIDTH-8){1'b0}}};

  typedef enum logic [2:0] {IDLE, SEND, WAIT, READ, CHECK, FIN} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [7:0]    rx_op;
  logic [15:0]   rx_ver;
  logic          unused_in;

`ifdef RAH_VERSION_RETRY_EN
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  logic [RW-1:0] retry_cnt;
`else
  localparam int unused_max_retries = MAX_RETRIES;
`endif

  // Queue strobes are gated by the live flags so they never fire into a full/empty queue.
  assign w_en         = (state == SEND) && !tx_full;
  assign request_data = (state == WAIT) && !q_empty;
  assign out_data     = w_en ? REQ_PKT : '0;
  assign unused_in    = ^in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tcnt       <= '0;
      rx_op      <= '0;
      rx_ver     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
      timeout    <= 1'b0;
      rx_version <= '0;
`ifdef RAH_VERSION_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= SEND;
            busy       <= 1'b1;
            match      <= 1'b0;
            timeout    <= 1'b0;
            rx_version <= '0;
`ifdef RAH_VERSION_RETRY_EN
            retry_cnt  <= '0;
`endif
          end
        end
        SEND: begin
          if (!tx_full) begin
            state <= WAIT;
            tcnt  <= '0;
          end
        end
        WAIT: begin
          if (!q_empty) begin
            state <= READ;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 2)) begin
            // Counter is about to reach TIMEOUT_CYCLES-1: attempt expires.
`ifdef RAH_VERSION_RETRY_EN
            if (retry_cnt < RW'(MAX_RETRIES)) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= SEND;
            end else begin
              timeout <= 1'b1;
              done    <= 1'b1;
              state   <= FIN;
            end
`else
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= FIN;
`endif
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        READ: begin
          rx_op  <= in_data[RAH_PACKET_WIDTH-1 -: 8];
          rx_ver <= in_data[15:0];
          state  <= CHECK;
        end
        CHECK: begin
          if (rx_op == RSP_OPCODE) begin
            rx_version <= rx_ver;
            match      <= (rx_ver == EXPECTED_VERSION);
            done       <= 1'b1;
            state      <= FIN;
          end else begin
            state <= WAIT;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rah_version_request.sv
// Randomized bench for rah_version_request with a transaction-level expectation model.
module tb_rah_version_request;
  localparam int W = 32;
  localparam int T = 16;
`ifdef RAH_VERSION_RETRY_EN
  localparam int TO_WEN = 4;
  localparam bit RETRY  = 1'b1;
`else
  localparam int TO_WEN = 1;
  localparam bit RETRY  = 1'b0;
`endif
  localparam logic [W-1:0] REQ_PKT = {8'hA5, 24'h000000};

  logic         clk = 1'b0;
  logic         rst_n, start, q_empty, tx_full;
  logic         request_data, w_en, busy, done, match, timeout;
  logic [W-1:0] in_data, out_data;
  logic [15:0]  rx_version;

  always #5 clk = ~clk;

  rah_version_request #(.RAH_PACKET_WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .q_empty(q_empty),
    .request_data(request_data), .tx_full(tx_full), .w_en(w_en), .out_data(out_data),
    .busy(busy), .done(done), .match(match), .timeout(timeout), .rx_version(rx_version)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int wen_cnt, pop_cnt, done_cnt, first_wen, last_wen, last_pop, done_cyc;
  logic [W-1:0] rxq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] mkpkt(input logic [7:0] op, input logic [15:0] ver);
    logic [W-1:0] p;
    p = W'($urandom);
    p[W-1 -: 8] = op;
    p[15:0] = ver;
    return p;
  endfunction

  // One clock: sample outputs mid-low-phase, then model the RX queue pop after the edge.
  task automatic tick();
    bit pop_now;
    #1;
    pop_now = request_data;
    if (w_en) begin
      if (wen_cnt == 0) first_wen = cyc;
      wen_cnt++;
      last_wen = cyc;
      chk("out_data", out_data, REQ_PKT);
    end
    if (request_data) begin
      pop_cnt++;
      last_pop = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    chk("invariants", {29'd0, w_en & tx_full, request_data & q_empty, match & timeout}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (pop_now && rxq.size() > 0) in_data = rxq.pop_front();
    q_empty = (rxq.size() == 0);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clr_counts();
    wen_cnt = 0; pop_cnt = 0; done_cnt = 0;
    first_wen = -1; last_wen = -1; last_pop = -1; done_cyc = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {busy, done, match, timeout, w_en, request_data, rx_version, out_data != 0}, 23'd0);
  endtask

  task automatic run_txn(input int k, input bit has_resp, input logic [15:0] ver,
                         input int bp, input int dly, input bit extra_start);
    int n, start_cyc;
    logic [7:0] op;
    logic [W-1:0] pkts[$];
    pkts.delete();
    for (int i = 0; i < k; i++) begin
      op = 8'($urandom_range(0, 255));
      if (op == 8'h5A) op = 8'h11;
      pkts.push_back(mkpkt(op, 16'($urandom)));
    end
    if (has_resp) pkts.push_back(mkpkt(8'h5A, ver));
    clr_counts();
    start_cyc = cyc;
    start = 1'b1;
    tx_full = (bp > 0);
    tick();
    for (int i = 0; i < bp; i++) tick();
    if (bp > 0) begin
      chk("bp_no_wen", wen_cnt, 0);
      chk("bp_no_timeout", timeout, 0);
      chk("bp_busy", busy, 1);
    end
    tx_full = 1'b0;
    n = 0;
    while (wen_cnt == 0 && n < 50) begin tick(); n++; end
    chk("start_to_wen", first_wen - start_cyc, 1 + bp);
    chk("busy_in_wait", busy, 1);
    start = extra_start;
    tick();
    repeat (dly) tick();
    foreach (pkts[i]) rxq.push_back(pkts[i]);
    q_empty = (rxq.size() == 0);
    n = 0;
    while (done_cnt == 0 && n < 500) begin tick(); n++; end
    chk("done_within_bound", done_cnt > 0, 1);
    repeat (4) tick();
    chk("done_once", done_cnt, 1);
    chk("busy_after", busy, 0);
    chk("match", match, has_resp && ver == 16'h0001);
    chk("timeout", timeout, !has_resp);
    chk("rx_version", rx_version, has_resp ? ver : 16'h0000);
    chk("pops", pop_cnt, k + int'(has_resp));
    chk("wen_count", wen_cnt, has_resp ? 1 : TO_WEN);
    if (has_resp) chk("rsp_latency", done_cyc - last_pop, 3);
    else chk("to_latency", done_cyc - last_wen, T + 3 * (RETRY ? 0 : k));
    chk("rxq_drained", rxq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_full = 1'b0; q_empty = 1'b1; in_data = '0;
    clr_counts();
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, 1'b1, 16'h0001, 0, 0, 1'b0);
    chk("pre_reset_match", match, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_idle");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(0, 1'b1, 16'h0002, 0, 2, 1'b0);
    run_txn(3, 1'b1, 16'h0001, 0, 1, 1'b0);
    run_txn(0, 1'b0, 16'h0000, 0, 0, 1'b0);
    run_txn(2, 1'b0, 16'h0000, 0, 3, 1'b1);
    run_txn(0, 1'b1, 16'h0001, 20, 3, 1'b1);

    // Abort from WAIT with a packet just offered: everything drops at once, no done follows.
    clr_counts();
    start = 1'b1;
    repeat (4) tick();
    chk("abort_busy_pre", busy, 1);
    rxq.push_back(mkpkt(8'h5A, 16'h0001));
    q_empty = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_wait");
    tick(); tick();
    rxq.delete();
    q_empty = 1'b1;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_pop", pop_cnt, 0);
    run_txn(1, 1'b1, 16'h0001, 0, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_txn($urandom_range(0, 3),
              $urandom_range(0, 3) != 0,
              ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'($urandom),
              ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 8),
              $urandom_range(0, T - 4),
              $urandom_range(0, 1) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rah_version_request.md
# rah_version_request

Initiator side of the RAH version handshake. On `start`, it pushes one version-request packet into the TX packet queue. It then drains the RX packet queue until a version-response packet arrives, compares the returned version against a compile-time expected value, and reports match, mismatch or timeout. It sits between the host-facing RAH queues and local application control logic that must confirm protocol compatibility before normal traffic begins.

## Interface
- `RAH_PACKET_WIDTH`, from `rah_var_defs.vh`: packet width, ≥ 24.
- `EXPECTED_VERSION`, default 16'h0001: version the peer must return.
- `REQ_OPCODE`, default 8'hA5: opcode placed in request packets.
- `RSP_OPCODE`, default 8'h5A: opcode recognised as a version response.
- `TIMEOUT_CYCLES`, default 1024: cycles to wait for a response per attempt; ≥ 2.
- `MAX_RETRIES`, default 3: extra attempts after a timeout; used only with the config macro.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that starts a check; ignored while `busy`.
- `in_data`  in  RAH_PACKET_WIDTH  RX queue read data; valid the cycle after `request_data`.
- `q_empty`  in  1  RX queue empty.
- `request_data`  out  1  RX queue pop strobe.
- `tx_full`  in  1  TX queue full.
- `w_en`  out  1  TX queue write strobe.
- `out_data`  out  RAH_PACKET_WIDTH  TX queue write data.
- `busy`  out  1  a check is in progress.
- `done`  out  1  one-cycle pulse when a check ends.
- `match`  out  1  returned version equals EXPECTED_VERSION; held until the next `start`.
- `timeout`  out  1  no response arrived; held until the next `start`.
- `rx_version`  out  16  last version received; held until the next `start`.

## Operation
- Packet format: opcode in `[RAH_PACKET_WIDTH-1 -: 8]`; version in `[15:0]`; all other bits are 0 on TX and ignored on RX.
- Request packet: opcode = REQ_OPCODE, all remaining bits 0.
- FSM states: IDLE, SEND, WAIT, READ, CHECK, FIN.
- IDLE → SEND on `start`. Entering SEND clears `match`, `timeout` and `rx_version`, clears the retry count, and sets `busy`.
- SEND: if `tx_full` = 0, drive `w_en` = 1 with the request packet for exactly one cycle, then go to WAIT and clear the timeout counter. While `tx_full` = 1, hold in SEND; the timeout counter does not run.
- WAIT: if `q_empty` = 0, pulse `request_data` for one cycle and go to READ. Otherwise increment the timeout counter. When the counter reaches TIMEOUT_CYCLES−1, take the timeout path (see Configuration).
- READ: capture `in_data`, then go to CHECK.
- CHECK:
  - If the opcode equals RSP_OPCODE: load `rx_version`, set `match` = (version == EXPECTED_VERSION), go to FIN.
  - Otherwise: discard the packet and return to WAIT. The timeout counter is not cleared.
- FIN: pulse `done` for one cycle, clear `busy`, go to IDLE.
- Non-response packets are always consumed, never pushed back.
- `start` while `busy` is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters 0. Asserting `rst_n` mid-check aborts immediately, with no `done` pulse.
- `start` at cycle 0 → `w_en` at cycle 1 if `tx_full` = 0.
- Response latency: `request_data` at cycle N, `in_data` sampled at N+1, result flags valid and `done` = 1 at N+3.
- `request_data` is never asserted while `q_empty` = 1. `w_en` is never asserted while `tx_full` = 1.
- At most one outstanding pop: no new `request_data` until the popped packet has been checked.
- `match` and `timeout` are never both 1.

## Configuration
- `RAH_VERSION_RETRY_EN` defined:
  - On the timeout path, if retry count < MAX_RETRIES, increment it and return to SEND to re-issue the request.
  - Otherwise set `timeout` = 1 and go to FIN.
- Not defined: the first expiry sets `timeout` = 1 and goes to FIN. The retry counter and MAX_RETRIES are not synthesised.

## Test plan
- Normal check: `start`; TX sees `out_data` with opcode 8'hA5. Queue one packet with opcode 8'h5A, version 16'h0001 → `done` pulse, `match` = 1, `rx_version` = 16'h0001, `timeout` = 0.
- Version mismatch: response carrying 16'h0002 → `match` = 0, `rx_version` = 16'h0002, `done` pulses once.
- Junk packets: queue 3 packets with opcode 8'h11, then a valid response → 4 `request_data` pulses; the result reflects only the final packet.
- Timeout, macro undefined: `q_empty` held at 1 → `done` and `timeout` = 1 exactly TIMEOUT_CYCLES cycles after `w_en`; exactly one `w_en` pulse.
- Retry, macro defined, MAX_RETRIES = 3: no response → 4 `w_en` pulses, then `timeout` = 1. Supplying a response after the 2nd request → `match` = 1 and no further `w_en`.
- Backpressure and reset: `tx_full` = 1 for 20 cycles after `start` → no `w_en` and no timeout in that window. Dropping `rst_n` in WAIT → all outputs 0 immediately; a fresh `start` then completes normally.
